// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, write-request type and write-port priority select
package regfile_pkg;
  localparam int REGFILE_WIDTH = 32;
  localparam int REGFILE_DEPTH = 32;
  localparam int REGFILE_MAX_WIDTH = 64;
  localparam int REGFILE_MAX_AW = 8;
  localparam int REGFILE_MAX_WR = 2;
  typedef struct packed {
    logic en;
    logic [REGFILE_MAX_AW-1:0] adr;
    logic [REGFILE_MAX_WIDTH-1:0] data;
  } wr_req_t;
  // highest-index enabled port writing adr wins; en=0 when no port hits
  function automatic wr_req_t wr_select(input wr_req_t [REGFILE_MAX_WR-1:0] reqs,
                                        input logic [REGFILE_MAX_AW-1:0] adr);
    wr_select = '0;
    for (int i = 0; i < REGFILE_MAX_WR; i++)
      if (reqs[i].en && reqs[i].adr == adr) wr_select = reqs[i];
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: ID/WB-facing read, write and reservation bus of the register file
interface regfile_mp_if #(
  parameter int WIDTH = regfile_pkg::REGFILE_WIDTH,
  parameter int DEPTH = regfile_pkg::REGFILE_DEPTH,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [RD_PORTS-1:0][AW-1:0] rdAdr;
  logic [RD_PORTS-1:0][WIDTH-1:0] rdData;
  logic [RD_PORTS-1:0] rdPending;
  logic [WR_PORTS-1:0] wrEn;
  logic [WR_PORTS-1:0][AW-1:0] wrAdr;
  logic [WR_PORTS-1:0][WIDTH-1:0] wrData;
  logic resvEn;
  logic [AW-1:0] resvAdr;
  logic [CW-1:0] pendCount;
  modport master (output rdAdr, wrEn, wrAdr, wrData, resvEn, resvAdr,
                  input rdData, rdPending, pendCount);
  modport slave (input rdAdr, wrEn, wrAdr, wrData, resvEn, resvAdr,
                 output rdData, rdPending, pendCount);
endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass: per-read-port write forwarding and bypass-aware pending bit
module regfile_bypass import regfile_pkg::*; #(
  parameter int WIDTH = REGFILE_WIDTH,
  parameter int AW = 5
) (
  input  logic [AW-1:0] rd_adr,
  input  wr_req_t [REGFILE_MAX_WR-1:0] reqs,
  input  logic [WIDTH-1:0] word,
  input  logic pend,
  output logic [WIDTH-1:0] data,
  output logic pending
);
  wr_req_t sel;
  assign sel = wr_select(reqs, REGFILE_MAX_AW'(rd_adr));
  assign data = sel.en ? sel.data[WIDTH-1:0] : word;
  assign pending = pend & ~sel.en;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with same-cycle bypass and pending scoreboard
module regfile_mp import regfile_pkg::*; #(
  parameter int WIDTH = REGFILE_WIDTH,
  parameter int DEPTH = REGFILE_DEPTH,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rstN,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend, pend_nxt;
  logic [CW-1:0] count;
  logic resv_ok;
  wr_req_t [REGFILE_MAX_WR-1:0] reqs;
  // requests are masked in reset so nothing is forwarded or written
  for (genvar p = 0; p < REGFILE_MAX_WR; p++) begin : g_req
    if (p < WR_PORTS) begin : g_on
      assign reqs[p].en = rstN && bus.wrEn[p] && !(ZERO_REG != 0 && bus.wrAdr[p] == '0);
      assign reqs[p].adr = REGFILE_MAX_AW'(bus.wrAdr[p]);
      assign reqs[p].data = REGFILE_MAX_WIDTH'(bus.wrData[p]);
    end else begin : g_off
      assign reqs[p] = '0;
    end
  end
  assign resv_ok = bus.resvEn && !(ZERO_REG != 0 && bus.resvAdr == '0);
  always_comb begin
    pend_nxt = pend;
    for (int p = 0; p < REGFILE_MAX_WR; p++)
      if (reqs[p].en) pend_nxt[AW'(reqs[p].adr)] = 1'b0;
    if (resv_ok) pend_nxt[bus.resvAdr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend <= '0;
      count <= '0;
    end else begin
      for (int p = 0; p < REGFILE_MAX_WR; p++)
        if (reqs[p].en) regs[AW'(reqs[p].adr)] <= reqs[p].data[WIDTH-1:0];
      pend <= pend_nxt;
      count <= count + CW'($countones(pend_nxt & ~pend)) - CW'($countones(pend & ~pend_nxt));
    end
  end
  for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
    regfile_bypass #(.WIDTH(WIDTH), .AW(AW)) u_bypass (
      .rd_adr(bus.rdAdr[r]),
      .reqs(reqs),
      .word(regs[bus.rdAdr[r]]),
      .pend(pend[bus.rdAdr[r]]),
      .data(bus.rdData[r]),
      .pending(bus.rdPending[r])
    );
  end
  assign bus.pendCount = count;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of the default config plus a 64x16 4R1W sweep
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] m [16];
  always #5 clk = ~clk;
  regfile_mp_if #(.WIDTH(32), .DEPTH(32), .RD_PORTS(2), .WR_PORTS(2)) b0 ();
  regfile_mp_if #(.WIDTH(64), .DEPTH(16), .RD_PORTS(4), .WR_PORTS(1)) b1 ();
  regfile_mp #(.WIDTH(32), .DEPTH(32), .RD_PORTS(2), .WR_PORTS(2), .ZERO_REG(1)) dut0 (
    .clk(clk), .rstN(rstN), .bus(b0.slave));
  regfile_mp #(.WIDTH(64), .DEPTH(16), .RD_PORTS(4), .WR_PORTS(1), .ZERO_REG(1)) dut1 (
    .clk(clk), .rstN(rstN), .bus(b1.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    b0.wrEn = '0;
    b0.resvEn = 1'b0;
    b1.wrEn = '0;
    b1.resvEn = 1'b0;
  endtask

  task automatic test_reset;
    b0.rdAdr = '0; b0.wrAdr = '0; b0.wrData = '0; b0.resvAdr = '0;
    b1.rdAdr = '0; b1.wrAdr = '0; b1.wrData = '0; b1.resvAdr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (b0.pendCount !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", b0.pendCount); end
    rstN = 1'b1;
    for (int a = 0; a < 32; a++) begin
      b0.rdAdr[0] = 5'(a);
      b0.rdAdr[1] = 5'(31 - a);
      @(negedge clk);
      checks++;
      if (b0.rdData[0] !== 32'h0 || b0.rdData[1] !== 32'h0 || b0.rdPending !== 2'b00) begin
        errors++; $display("FAIL reset_read adr %0d got %h %h pend %b exp 0 0 00", a, b0.rdData[0], b0.rdData[1], b0.rdPending);
      end
    end
    tick();
    b0.wrEn = 2'b01; b0.wrAdr[0] = 5'd5; b0.wrData[0] = 32'hDEADBEEF; b0.rdAdr[0] = 5'd5;
    #1;
    checks++;
    if (b0.rdData[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_bypass got %h exp deadbeef", b0.rdData[0]); end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (b0.rdData[0] !== 32'h0) begin errors++; $display("FAIL reset_bypass_off got %h exp 0", b0.rdData[0]); end
    tick();
    idle();
    rstN = 1'b1;
    tick();
    checks++;
    if (b0.rdData[0] !== 32'h0) begin errors++; $display("FAIL reset_discard got %h exp 0", b0.rdData[0]); end
  endtask

  task automatic test_dual_write;
    b0.wrEn = 2'b11; b0.wrAdr[0] = 5'd3; b0.wrAdr[1] = 5'd3;
    b0.wrData[0] = 32'h11; b0.wrData[1] = 32'h22; b0.rdAdr[0] = 5'd3;
    #1;
    checks++;
    if (b0.rdData[0] !== 32'h22) begin errors++; $display("FAIL dual_bypass got %h exp 22", b0.rdData[0]); end
    tick();
    idle();
    #1;
    checks++;
    if (b0.rdData[0] !== 32'h22) begin errors++; $display("FAIL dual_stored got %h exp 22", b0.rdData[0]); end
  endtask

  task automatic test_zero_reg;
    b0.wrEn = 2'b10; b0.wrAdr[1] = 5'd0; b0.wrData[1] = 32'hFFFFFFFF; b0.rdAdr[0] = 5'd0;
    b0.resvEn = 1'b1; b0.resvAdr = 5'd0;
    #1;
    checks++;
    if (b0.rdData[0] !== 32'h0) begin errors++; $display("FAIL zero_bypass got %h exp 0", b0.rdData[0]); end
    tick();
    idle();
    #1;
    checks++;
    if (b0.rdData[0] !== 32'h0 || b0.rdPending[0] !== 1'b0) begin
      errors++; $display("FAIL zero_stored got %h pend %b exp 0 0", b0.rdData[0], b0.rdPending[0]);
    end
    checks++;
    if (b0.pendCount !== 6'd0) begin errors++; $display("FAIL zero_resv_count got %0d exp 0", b0.pendCount); end
  endtask

  task automatic test_reserve;
    b0.resvEn = 1'b1; b0.resvAdr = 5'd8; b0.rdAdr[1] = 5'd8;
    #1;
    checks++;
    if (b0.rdPending[1] !== 1'b0) begin errors++; $display("FAIL resv_same_cycle got %b exp 0", b0.rdPending[1]); end
    tick();
    idle();
    #1;
    checks++;
    if (b0.rdPending[1] !== 1'b1 || b0.pendCount !== 6'd1) begin
      errors++; $display("FAIL resv_next got pend %b count %0d exp 1 1", b0.rdPending[1], b0.pendCount);
    end
  endtask

  task automatic test_write_clears;
    b0.wrEn = 2'b01; b0.wrAdr[0] = 5'd8; b0.wrData[0] = 32'd80;
    #1;
    checks++;
    if (b0.rdPending[1] !== 1'b0 || b0.rdData[1] !== 32'd80) begin
      errors++; $display("FAIL clear_bypass got pend %b data %0d exp 0 80", b0.rdPending[1], b0.rdData[1]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (b0.rdPending[1] !== 1'b0 || b0.pendCount !== 6'd0 || b0.rdData[1] !== 32'd80) begin
      errors++; $display("FAIL clear_after got pend %b count %0d data %0d exp 0 0 80", b0.rdPending[1], b0.pendCount, b0.rdData[1]);
    end
  endtask

  task automatic test_set_wins;
    b0.resvEn = 1'b1; b0.resvAdr = 5'd9;
    b0.wrEn = 2'b01; b0.wrAdr[0] = 5'd9; b0.wrData[0] = 32'd7;
    tick();
    idle();
    b0.rdAdr[0] = 5'd9;
    #1;
    checks++;
    if (b0.rdPending[0] !== 1'b1 || b0.rdData[0] !== 32'd7 || b0.pendCount !== 6'd1) begin
      errors++; $display("FAIL set_wins got pend %b data %0d count %0d exp 1 7 1", b0.rdPending[0], b0.rdData[0], b0.pendCount);
    end
    b0.resvEn = 1'b1; b0.resvAdr = 5'd10;
    b0.wrEn = 2'b10; b0.wrAdr[1] = 5'd9; b0.wrData[1] = 32'd99;
    tick();
    idle();
    b0.rdAdr[1] = 5'd10;
    #1;
    checks++;
    if (b0.pendCount !== 6'd1 || b0.rdPending !== 2'b10 || b0.rdData[0] !== 32'd99) begin
      errors++; $display("FAIL swap_net0 got count %0d pend %b data %0d exp 1 10 99", b0.pendCount, b0.rdPending, b0.rdData[0]);
    end
    b0.resvEn = 1'b1; b0.resvAdr = 5'd10;
    tick();
    idle();
    checks++;
    if (b0.pendCount !== 6'd1) begin errors++; $display("FAIL re_resv got count %0d exp 1", b0.pendCount); end
  endtask

  task automatic test_sweep;
    logic we;
    logic [3:0] wa;
    logic [63:0] wd, ex;
    for (int a = 0; a < 16; a++) begin
      b1.resvEn = 1'b1; b1.resvAdr = 4'(a);
      tick();
    end
    idle();
    #1;
    checks++;
    if (b1.pendCount !== 5'd15) begin errors++; $display("FAIL sweep_full got %0d exp 15", b1.pendCount); end
    m[0] = '0;
    for (int a = 1; a < 16; a++) begin
      b1.wrEn = 1'b1; b1.wrAdr[0] = 4'(a); b1.wrData[0] = {32'hA5A5_0000, 32'(a)};
      m[a] = {32'hA5A5_0000, 32'(a)};
      tick();
    end
    idle();
    #1;
    checks++;
    if (b1.pendCount !== 5'd0) begin errors++; $display("FAIL sweep_empty got %0d exp 0", b1.pendCount); end
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      wd = {$urandom(), $urandom()};
      b1.wrEn = we; b1.wrAdr[0] = wa; b1.wrData[0] = wd;
      for (int r = 0; r < 4; r++) b1.rdAdr[r] = (r == 0) ? wa : 4'($urandom_range(0, 15));
      #1;
      for (int r = 0; r < 4; r++) begin
        ex = (b1.rdAdr[r] == 4'd0) ? 64'd0 : (we && wa == b1.rdAdr[r]) ? wd : m[b1.rdAdr[r]];
        checks++;
        if (b1.rdData[r] !== ex) begin
          errors++; $display("FAIL sweep_read n %0d port %0d adr %0d got %h exp %h", n, r, b1.rdAdr[r], b1.rdData[r], ex);
        end
      end
      tick();
      if (we && wa != 4'd0) m[wa] = wd;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_zero_reg();
    test_reserve();
    test_write_clears();
    test_set_wins();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS pipeline core, successor to the single-write, dual-read integer register file. It provides configurable width, depth and read/write port counts. Same-cycle write-to-read bypass replaces negative-edge writes. A per-register pending scoreboard lets the decode stage detect RAW hazards against in-flight producers. It sits between ID (reads, reservations) and WB (writes).

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of architectural registers (power of two, ≥ 2)
- RD_PORTS, 2, number of read ports (1..4)
- WR_PORTS, 2, number of write ports (1..2); higher index has priority
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending
- AW, $clog2(DEPTH), derived address width (localparam)
- clk  in  1  single clock; all state updates on rising edge
- rstN  in  1  asynchronous, active-low reset
- rdAdr  in  RD_PORTS×AW  read addresses
- rdData  out  RD_PORTS×WIDTH  read data (combinational, bypassed)
- rdPending  out  RD_PORTS  scoreboard bit of addressed register (bypass-aware)
- wrEn  in  WR_PORTS  write enables
- wrAdr  in  WR_PORTS×AW  write addresses
- wrData  in  WR_PORTS×WIDTH  write data
- resvEn  in  1  reserve destination register (instruction issued)
- resvAdr  in  AW  register to mark pending
- pendCount  out  $clog2(DEPTH+1)  number of registers currently pending

## Operation
- Storage: DEPTH×WIDTH array `regs`, DEPTH-bit vector `pend`, counter `pendCount`.
- Write: on posedge, for each port with wrEn=1 (and wrAdr≠0 when ZERO_REG), set regs[wrAdr]=wrData. Same address on both ports: port WR_PORTS-1 wins.
- Write clears pend[wrAdr]. Reservation sets pend[resvAdr].
- Reserve and write to the same register in one cycle: set wins, pend stays 1, and the data is still written.
- resvAdr=0 with ZERO_REG=1 is ignored.
- Read: rdData[i] is the winning enabled write port's wrData when its wrAdr==rdAdr[i]; otherwise regs[rdAdr[i]]. rdAdr=0 with ZERO_REG returns 0 regardless of writes.
- rdPending[i] = pend[rdAdr[i]], forced 0 when a same-cycle write to that address is present (bypass satisfies the hazard). Reservations do not affect rdPending in the same cycle.
- pendCount equals the popcount of pend at all times. Update by +1 per 0→1 transition and −1 per 1→0 transition. Simultaneous set of reg A and clear of reg B gives a net 0 change.
- Write to a non-pending register: no count change, no error.
- Reservation of an already-pending register: no count change.

## Timing
- Reset (rstN=0, async): all regs=0, pend=0, pendCount=0. While in reset, rdData=0 and rdPending=0 on all ports, and bypass is suppressed.
- Reset asserted mid-cycle with writes/reservations active: they are discarded. Release is synchronous to the next posedge.
- Read latency 0 (combinational from rdAdr, wrEn/wrAdr/wrData, state). Write and reservation latency 1 cycle.
- Combinational path wrData→rdData is intentional. WB must present stable data before the ID sampling edge.
- pendCount never exceeds DEPTH-ZERO_REG and never underflows.

## Structure
- Package regfile_pkg holds:
  - default parameter constants (REGFILE_WIDTH=32, REGFILE_DEPTH=32);
  - the typedef for a write-request struct {en, adr, data};
  - the function for priority selection across write ports.
- Sub-module regfile_bypass: one instance per read port, generated. Inputs: rdAdr, write requests, array word, pend bit. Outputs: rdData, rdPending.
- Top handles the array, the scoreboard vector and pendCount.

## Test plan
- Reset, then read all 32 addresses on both ports → all 0, pendCount=0. Assert rstN=0 mid-write of reg 5=0xDEADBEEF → reg 5 stays 0.
- Write port0 reg 3=0x11, port1 reg 3=0x22 same cycle. Read reg 3 that cycle → 0x22 (bypass). Next cycle → 0x22 (stored).
- Write reg 0=0xFFFFFFFF with ZERO_REG=1 → reads 0 in that cycle and after. resvEn with resvAdr=0 → pendCount stays 0.
- Reserve reg 8 → next cycle rdPending=1, pendCount=1.
- Write reg 8=80 → rdPending=0 in the same cycle, rdData=80. After the edge pend[8]=0, pendCount=0.
- Same cycle: reserve reg 9 and write reg 9=7 → pend[9]=1, regs[9]=7, pendCount=1. Then reserve reg 10 and write reg 9 → pendCount stays 1.
- Parameter sweep WIDTH=64, DEPTH=16, RD_PORTS=4, WR_PORTS=1 → reserve all 15 nonzero registers, pendCount=15. Clear them all, pendCount=0. Random writes checked against a reference model.
